// File: rtl/stdp_weight_update.sv
// -----------------------------------------------------------------------------
// stdp_weight_update
//
// Applies one STDP weight update per request. The spike-time difference
// magnitude is driven to the potentiation and depression LUTs. The registered
// LUT value is captured two edges later. It is then added to the current weight
// (potentiation) or subtracted from it (depression), with saturation to
// [W_MIN, W_MAX]. The updated weight leaves on a valid/ready handshake.
//
// A dt_mag outside [DT_MIN, DT_MAX] still runs the full sequence with a zero
// delta. Latency is therefore fixed: w_valid rises 2 clocks after the accept
// edge, and requests can be spaced 4 cycles apart at best.
//
// Build option:
//   STDP_LR_SHIFT_EN - when defined, the LUT delta is logically right-shifted
//                      by LR_SHIFT before it is applied. Latency is unchanged.
//
// Ports:
//   clk        clock
//   rst        synchronous, active-high reset
//   req_valid  update request valid
//   req_ready  request can be accepted (IDLE and not in reset)
//   dt_mag     |t_post - t_pre| in timesteps
//   dt_neg     1 = depression (minus LUT), 0 = potentiation (plus LUT)
//   w_in       current weight (unsigned)
//   lut_idx    registered index driven to both LUTs
//   lut_plus   registered potentiation LUT output
//   lut_minus  registered depression LUT output
//   w_out      updated weight
//   w_valid    w_out valid
//   w_ready    downstream accepts w_out
// -----------------------------------------------------------------------------
module stdp_weight_update #(
   parameter int           W        = 24,
   parameter int           DT_MIN   = 2,
   parameter int           DT_MAX   = 20,
   parameter logic [W-1:0] W_MAX    = {W{1'b1}},
   parameter logic [W-1:0] W_MIN    = '0,
   parameter int           LR_SHIFT = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [7:0]   dt_mag,
   input  logic         dt_neg,
   input  logic [W-1:0] w_in,
   output logic [7:0]   lut_idx,
   input  logic [W-1:0] lut_plus,
   input  logic [W-1:0] lut_minus,
   output logic [W-1:0] w_out,
   output logic         w_valid,
   input  logic         w_ready
);

`ifdef STDP_LR_SHIFT_EN
   localparam bit LR_EN = 1'b1;
`else
   localparam bit LR_EN = 1'b0;
`endif

   localparam logic [7:0] DT_MIN_B = 8'(DT_MIN);
   localparam logic [7:0] DT_MAX_B = 8'(DT_MAX);

   // Two guard bits: one for add carry, one for a sign bit so that
   // subtraction underflow shows up as a negative value.
   localparam logic signed [W+1:0] W_MAX_S = $signed({2'b00, W_MAX});
   localparam logic signed [W+1:0] W_MIN_S = $signed({2'b00, W_MIN});

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      OUT     = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic accept;
   logic capture;
   logic release_out;

   // Request registers, loaded on the accept edge
   logic         dt_neg_p0;
   logic         in_win_p0;
   logic [W-1:0] w_p0;

   logic [W-1:0]        delta_sel;
   logic [W-1:0]        delta_eff;
   logic signed [W+1:0] w_ext;
   logic signed [W+1:0] d_ext;
   logic [W-1:0]        w_new;

   // Learning-rate scaling of the LUT delta. It is active only in the
   // STDP_LR_SHIFT_EN build.
   function automatic logic [W-1:0] scale_delta(input logic [W-1:0] d);
      logic [W-1:0] res;
      res = d;
      if (LR_EN)
         res = d >> LR_SHIFT;
      return res;
   endfunction

   // Saturates a signed intermediate result into [W_MIN, W_MAX]. This also
   // clamps incoming weights that already lie outside the bounds.
   function automatic logic [W-1:0] sat_clamp(input logic signed [W+1:0] r);
      logic [W-1:0] res;
      if (r > W_MAX_S)
         res = W_MAX;
      else if (r < W_MIN_S)
         res = W_MIN;
      else
         res = r[W-1:0];
      return res;
   endfunction

   assign req_ready = (state == IDLE) && !rst;

   // Control FSM: state register
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Control FSM: next state and datapath strobes
   always_comb begin
      state_nxt   = state;
      accept      = 1'b0;
      capture     = 1'b0;
      release_out = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               accept    = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            // The LUTs register lut_idx at this edge
            state_nxt = CAPTURE;
         end
         CAPTURE: begin
            capture   = 1'b1;
            state_nxt = OUT;
         end
         OUT: begin
            if (w_ready) begin
               release_out = 1'b1;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Update arithmetic, valid while the registered LUT outputs are in CAPTURE
   always_comb begin
      delta_sel = '0;
      if (in_win_p0)
         delta_sel = dt_neg_p0 ? lut_minus : lut_plus;
      delta_eff = scale_delta(delta_sel);
      w_ext     = $signed({2'b00, w_p0});
      d_ext     = $signed({2'b00, delta_eff});
      if (dt_neg_p0)
         w_new = sat_clamp(w_ext - d_ext);
      else
         w_new = sat_clamp(w_ext + d_ext);
   end

   // Accept edge -> request registers and LUT index; capture edge -> result
   always_ff @(posedge clk) begin
      if (rst) begin
         lut_idx   <= '0;
         dt_neg_p0 <= 1'b0;
         in_win_p0 <= 1'b0;
         w_p0      <= '0;
         w_out     <= '0;
         w_valid   <= 1'b0;
      end else begin
         if (accept) begin
            lut_idx   <= dt_mag;
            dt_neg_p0 <= dt_neg;
            w_p0      <= w_in;
            in_win_p0 <= (dt_mag >= DT_MIN_B) && (dt_mag <= DT_MAX_B);
         end
         if (capture) begin
            w_out   <= w_new;
            w_valid <= 1'b1;
         end else if (release_out) begin
            w_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stdp_weight_update.sv
// -----------------------------------------------------------------------------
// Testbench for stdp_weight_update. It contains a registered LUT model and a
// reference model of the weight update. The reference model works in plain
// integer arithmetic with a saturating clamp.
// -----------------------------------------------------------------------------
module tb_stdp_weight_update;

   localparam int     W        = 24;
   localparam int     DT_MIN   = 2;
   localparam int     DT_MAX   = 20;
   localparam int     LR_SHIFT = 2;
   localparam longint WMAX     = (longint'(1) << W) - 1;
   localparam longint WMIN     = 0;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid;
   logic         req_ready;
   logic [7:0]   dt_mag;
   logic         dt_neg;
   logic [W-1:0] w_in;
   logic [7:0]   lut_idx;
   logic [W-1:0] lut_plus;
   logic [W-1:0] lut_minus;
   logic [W-1:0] w_out;
   logic         w_valid;
   logic         w_ready;

   logic [W-1:0] lut_p_mem [256];
   logic [W-1:0] lut_m_mem [256];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   stdp_weight_update #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .dt_mag    (dt_mag),
      .dt_neg    (dt_neg),
      .w_in      (w_in),
      .lut_idx   (lut_idx),
      .lut_plus  (lut_plus),
      .lut_minus (lut_minus),
      .w_out     (w_out),
      .w_valid   (w_valid),
      .w_ready   (w_ready)
   );

   // Registered LUTs: one clock from index to data
   always @(posedge clk) begin
      lut_plus  <= lut_p_mem[lut_idx];
      lut_minus <= lut_m_mem[lut_idx];
   end

   function automatic logic [W-1:0] model(input logic [W-1:0] w, input int dt, input logic neg);
      longint d, r;
      d = 0;
      if (dt >= DT_MIN && dt <= DT_MAX)
         d = neg ? longint'(lut_m_mem[dt]) : longint'(lut_p_mem[dt]);
`ifdef STDP_LR_SHIFT_EN
      d = d / (longint'(1) << LR_SHIFT);
`endif
      r = neg ? longint'(w) - d : longint'(w) + d;
      if (r > WMAX) r = WMAX;
      if (r < WMIN) r = WMIN;
      return W'(r);
   endfunction

   // Drives one request and returns the observed result, the latency in edges
   // after the accept edge (0 = timed out) and the LUT index after the accept.
   task automatic run_req(input logic [W-1:0] w, input logic [7:0] dt, input logic neg,
                          output logic [W-1:0] wo, output int lat, output logic [7:0] idx);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      req_valid = 1'b1;
      w_in      = w;
      dt_mag    = dt;
      dt_neg    = neg;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      w_in      = W'($urandom);
      dt_mag    = 8'($urandom);
      dt_neg    = 1'($urandom);
      idx       = lut_idx;
      lat       = 0;
      wo        = 'x;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk);
         #1;
         if (w_valid) begin
            lat = i;
            wo  = w_out;
            break;
         end
      end
      if (w_ready && lat != 0) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      req_valid = 1'b0;
      w_ready   = 1'b1;
      dt_mag    = '0;
      dt_neg    = 1'b0;
      w_in      = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (lut_idx !== 8'd0) begin failures++; $display("FAIL reset_lut_idx: got %0h want 0", lut_idx); end
      checks++; if (w_out !== '0) begin failures++; $display("FAIL reset_w_out: got %0h want 0", w_out); end
      checks++; if (w_valid !== 1'b0) begin failures++; $display("FAIL reset_w_valid: got %0b want 0", w_valid); end
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready_in_rst: got %0b want 0", req_ready); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready_after: got %0b want 1", req_ready); end
   endtask

   task automatic test_depression_mid();
      logic [W-1:0] wo, exp;
      int lat;
      logic [7:0] idx;
      lut_m_mem[2] = 24'h000149;
      exp = model(24'd1000, 2, 1'b1);
      run_req(24'd1000, 8'd2, 1'b1, wo, lat, idx);
      checks++; if (idx !== 8'd2) begin failures++; $display("FAIL dep_mid_idx: got %0d want 2", idx); end
      checks++; if (lat != 2) begin failures++; $display("FAIL dep_mid_latency: got %0d want 2", lat); end
      checks++; if (wo !== exp) begin failures++; $display("FAIL dep_mid_w_out: got %0d want %0d", wo, exp); end
   endtask

   task automatic test_depression_sat();
      logic [W-1:0] wo, exp;
      int lat;
      logic [7:0] idx;
      lut_m_mem[20] = 24'd9;
      exp = model(24'd5, 20, 1'b1);
      run_req(24'd5, 8'd20, 1'b1, wo, lat, idx);
      checks++; if (lat != 2) begin failures++; $display("FAIL dep_sat_latency: got %0d want 2", lat); end
      checks++; if (wo !== exp) begin failures++; $display("FAIL dep_sat_w_out: got %0d want %0d", wo, exp); end
   endtask

   task automatic test_potentiation_sat();
      logic [W-1:0] wo, exp;
      int lat;
      logic [7:0] idx;
      lut_p_mem[5] = 24'h000100;
      exp = model(24'hFFFFF0, 5, 1'b0);
      run_req(24'hFFFFF0, 8'd5, 1'b0, wo, lat, idx);
      checks++; if (lat != 2) begin failures++; $display("FAIL pot_sat_latency: got %0d want 2", lat); end
      checks++; if (wo !== exp) begin failures++; $display("FAIL pot_sat_w_out: got %0h want %0h", wo, exp); end
      exp = model(24'h001000, 5, 1'b0);
      run_req(24'h001000, 8'd5, 1'b0, wo, lat, idx);
      checks++; if (wo !== exp) begin failures++; $display("FAIL pot_mid_w_out: got %0h want %0h", wo, exp); end
   endtask

   task automatic test_out_of_window();
      logic [W-1:0] wo;
      int lat;
      logic [7:0] idx;
      logic [7:0] dts [4];
      dts[0] = 8'd25; dts[1] = 8'd0; dts[2] = 8'd1; dts[3] = 8'd21;
      for (int k = 0; k < 4; k++) begin
         lut_p_mem[dts[k]] = W'($urandom) | 24'h1;
         lut_m_mem[dts[k]] = W'($urandom) | 24'h1;
         run_req(24'd1234, dts[k], 1'(k), wo, lat, idx);
         checks++; if (wo !== 24'd1234) begin failures++; $display("FAIL oow_w_out dt=%0d: got %0d want 1234", dts[k], wo); end
         checks++; if (lat != 2) begin failures++; $display("FAIL oow_latency dt=%0d: got %0d want 2", dts[k], lat); end
         checks++; if (idx !== dts[k]) begin failures++; $display("FAIL oow_idx: got %0d want %0d", idx, dts[k]); end
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] wo0, exp;
      int waited;
      lut_p_mem[3] = 24'h000321;
      exp = model(24'h00ABCD, 3, 1'b0);
      w_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b1;
      w_in      = 24'h00ABCD;
      dt_mag    = 8'd3;
      dt_neg    = 1'b0;
      @(posedge clk);
      #1;
      // Hold a second, different request pending while the result is stalled
      dt_mag = 8'd7;
      w_in   = 24'd42;
      waited = 0;
      while (!w_valid && waited < 8) begin
         @(posedge clk);
         #1;
         waited++;
      end
      checks++; if (waited != 2) begin failures++; $display("FAIL bp_latency: got %0d want 2", waited); end
      wo0 = w_out;
      checks++; if (wo0 !== exp) begin failures++; $display("FAIL bp_w_out: got %0h want %0h", wo0, exp); end
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         checks++; if (w_valid !== 1'b1 || w_out !== wo0 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold c=%0d: got valid=%0b w=%0h ready=%0b want valid=1 w=%0h ready=0", c, w_valid, w_out, req_ready, wo0);
         end
      end
      @(negedge clk);
      w_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (w_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid: got %0b want 0", w_valid); end
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %0b want 1", req_ready); end
      checks++; if (lut_idx !== 8'd3) begin failures++; $display("FAIL bp_no_same_cycle_accept: lut_idx got %0d want 3", lut_idx); end
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] wo, exp;
      int lat, pulses;
      logic [7:0] idx;
      w_ready = 1'b1;
      lut_p_mem[4] = 24'h000050;
      @(negedge clk);
      req_valid = 1'b1;
      w_in      = 24'd500;
      dt_mag    = 8'd4;
      dt_neg    = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (w_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid: got %0b want 0", w_valid); end
      checks++; if (w_out !== '0) begin failures++; $display("FAIL rst_mid_w_out: got %0h want 0", w_out); end
      checks++; if (lut_idx !== 8'd0) begin failures++; $display("FAIL rst_mid_lut_idx: got %0d want 0", lut_idx); end
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (w_valid) pulses++;
      end
      checks++; if (pulses != 0) begin failures++; $display("FAIL rst_mid_no_pulse: got %0d pulses want 0", pulses); end
      exp = model(24'd700, 4, 1'b0);
      run_req(24'd700, 8'd4, 1'b0, wo, lat, idx);
      checks++; if (wo !== exp || lat != 2) begin failures++; $display("FAIL rst_mid_followup: got w=%0h lat=%0d want w=%0h lat=2", wo, lat, exp); end
   endtask

   task automatic test_random();
      logic [W-1:0] wo, exp, w;
      int lat, dt;
      logic neg;
      logic [7:0] idx;
      for (int n = 0; n < 40; n++) begin
         dt  = $urandom_range(0, 30);
         neg = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 2))
            0: w = W'($urandom);
            1: w = 24'hFFFFFF - W'($urandom_range(0, 255));
            default: w = W'($urandom_range(0, 255));
         endcase
         if ($urandom_range(0, 1) == 1) begin
            lut_p_mem[dt] = W'($urandom);
            lut_m_mem[dt] = W'($urandom);
         end else begin
            lut_p_mem[dt] = W'($urandom_range(0, 4095));
            lut_m_mem[dt] = W'($urandom_range(0, 4095));
         end
         exp = model(w, dt, neg);
         run_req(w, 8'(dt), neg, wo, lat, idx);
         checks++; if (wo !== exp) begin failures++; $display("FAIL rand_w_out n=%0d w=%0h dt=%0d neg=%0b: got %0h want %0h", n, w, dt, neg, wo, exp); end
         checks++; if (lat != 2) begin failures++; $display("FAIL rand_latency n=%0d: got %0d want 2", n, lat); end
         checks++; if (idx !== 8'(dt)) begin failures++; $display("FAIL rand_idx n=%0d: got %0d want %0d", n, idx, dt); end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         lut_p_mem[i] = W'($urandom);
         lut_m_mem[i] = W'($urandom);
      end
      test_reset();
      test_depression_mid();
      test_depression_sat();
      test_potentiation_sat();
      test_out_of_window();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stdp_weight_update.md
Name: stdp_weight_update

Overview:
- Downstream consumer of the STDP decay lookup tables (potentiation LUT and depression LUT).
- Accepts one synapse update request: current weight, spike-time difference magnitude and sign.
- Drives the LUT index, captures the registered LUT result one cycle later, and applies a saturating add (potentiation) or subtract (depression) to the weight.
- Returns the new weight over a valid/ready handshake to the synapse weight memory writer.

Parameters:
- W, 24, weight and LUT value width; matches the LUT output width.
- DT_MIN, 2, smallest |dt| for which an update is applied.
- DT_MAX, 20, largest |dt| for which an update is applied.
- W_MAX, 2^W-1, upper saturation bound for the weight.
- W_MIN, 0, lower saturation bound for the weight; weights are unsigned.
- LR_SHIFT, 2, learning-rate right shift; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high. Clock is clk.
- req_valid  in  1  update request valid
- req_ready  out  1  block can accept a request
- dt_mag  in  8  |t_post - t_pre| in timesteps
- dt_neg  in  1  1 = depression (post before pre, use minus LUT); 0 = potentiation (plus LUT)
- w_in  in  W  current weight
- lut_idx  out  8  index driven to both LUTs (registered)
- lut_plus  in  W  registered potentiation LUT output
- lut_minus  in  W  registered depression LUT output
- w_out  out  W  updated weight
- w_valid  out  1  w_out valid
- w_ready  in  1  downstream accepts w_out

Behaviour:
- Reset values: lut_idx=0, w_out=0, w_valid=0, state=IDLE; all internal request registers cleared.
- req_ready = (state==IDLE) && !rst, combinational.
- States: IDLE, ISSUE, CAPTURE, OUT.
- IDLE:
  - On an edge with req_valid && req_ready, latch dt_neg and w_in.
  - Set lut_idx <= dt_mag.
  - Set in_win <= (DT_MIN <= dt_mag <= DT_MAX).
  - Go to ISSUE.
- ISSUE: the LUTs register lut_idx at this edge; go to CAPTURE.
- CAPTURE: lut_plus and lut_minus are valid during this cycle.
  - delta = in_win ? (dt_neg ? lut_minus : lut_plus) : 0.
  - Potentiation: sum = w + delta computed in W+1 bits; w_out <= (sum > W_MAX) ? W_MAX : sum.
  - Depression: w_out <= (delta > w - W_MIN) ? W_MIN : w - delta.
  - Set w_valid <= 1 and go to OUT.
- OUT:
  - Hold w_out and w_valid stable while w_ready=0.
  - On an edge with w_ready=1, set w_valid <= 0 and go to IDLE.
  - No new request is accepted in the same cycle.
- Latency: w_valid rises 2 clocks after the accept edge. Minimum request spacing is 4 cycles.
- Out-of-window dt (including dt_mag=0, 1, or >DT_MAX): the full pipeline still runs and w_out = w_in. This keeps latency fixed.
- w_in outside [W_MIN, W_MAX]: result is still clamped to [W_MIN, W_MAX].
- lut_idx keeps its last value after a transaction; it is not cleared.
- rst asserted in any state: the next edge forces reset values and the in-flight transaction is discarded with no w_valid pulse.
- req_valid while not ready: ignored. The requester must hold its inputs until accepted.

Optional Feature:
- Macro: STDP_LR_SHIFT_EN.
- Defined: delta is right-shifted by LR_SHIFT (logical) before it is applied, i.e. delta_eff = delta >> LR_SHIFT.
- Not defined: delta is applied unscaled, and LR_SHIFT is unused.
- Latency is identical in both builds.

Test Plan:
- Depression, mid-range: bench LUT model returns lut_minus=0x000149 for idx 2. Request w_in=1000, dt_mag=2, dt_neg=1. Required: lut_idx=2, and w_out=671 with w_valid high 2 clocks after accept.
- Depression saturation: w_in=5, dt_mag=20, dt_neg=1, lut_minus=9. Required: w_out=0. With STDP_LR_SHIFT_EN and LR_SHIFT=2, required: w_out=3.
- Potentiation saturation: W_MAX=0xFFFFFF, w_in=0xFFFFF0, dt_mag=5, dt_neg=0, lut_plus=0x000100. Required: w_out=0xFFFFFF. With w_in=0x1000 instead, required: w_out=0x1100.
- Out of window: dt_mag=25 (then dt_mag=0), w_in=1234, with the LUT model returning nonzero garbage. Required: w_out=1234 both times, same latency.
- Backpressure: hold w_ready=0 for 5 cycles after w_valid. Required: w_out and w_valid stable, req_ready=0 throughout. Raise w_ready: w_valid drops next edge and req_ready=1.
- Reset mid-op: assert rst for 1 cycle while in CAPTURE. Required: no w_valid pulse, w_out=0, and a following request completes normally.
